mul_div_unit: RTL and testbench
===============================

# mul_div_unit

- Multi-cycle multiply/divide unit in the EX stage; executes MULT, MULTU, DIV and DIVU.
- Stalls the pipeline while computing, then writes the 64-bit result into the HI/LO registers of the register file.
- Drives the HI/LO forwarding bus that the register file reads, so the ID stage sees the new HI/LO values without waiting for write-back.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous and active-high
- start  in  1  launch request; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- src_a  in  32  multiplicand / dividend; sampled with start
- src_b  in  32  multiplier / divisor; sampled with start
- flush  in  1  synchronous abort; has priority over start
- stall_req  out  1  pipeline must hold EX and earlier stages
- done  out  1  one-cycle pulse; hi_o/lo_o are valid in this cycle
- hi_o  out  32  registered HI result; holds its value between operations
- lo_o  out  32  registered LO result; holds its value between operations
- hilo_bus  out  66  {done, done, hi_o, lo_o}; layout {hi_we, lo_we, hi, lo}, feeds the EX HI/LO forwarding input and the HI/LO write ports

## Operation
States: IDLE, CALC, FIN, DONE.
- IDLE
  - start=1 and flush=0: capture absolute values of the operands (signed ops only), sign flags and op; clear the 5-bit counter; go to CALC.
  - Divide op with src_b==0: skip CALC and go to FIN with the div-by-zero flag set.
- CALC: one iteration per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; 33-bit partial remainder, quotient bit shifted into LSB.
  - Counter increments each cycle; on count 31 go to FIN.
- FIN: apply sign correction, register hi_o/lo_o, go to DONE.
- DONE: done=1 for exactly one cycle; return to IDLE. start is ignored in DONE.

Arithmetic rules:
- Absolute value of 0x80000000 is taken as unsigned 0x80000000; no overflow handling is needed.
- MULT: product negated (64-bit two's complement) if the operand signs differ. HI = product[63:32], LO = product[31:0].
- DIV: LO = quotient, negated if the operand signs differ. HI = remainder, negated if the dividend is negative.
- MULTU/DIVU: no sign correction.
- Divide by zero (DIV or DIVU): HI = src_a as captured, LO = 0xFFFFFFFF.
- 0x80000000 DIV 0xFFFFFFFF: LO = 0x80000000, HI = 0.

Control rules:
- stall_req = (IDLE & start & ~flush) | CALC | FIN. It is deasserted in DONE so the pipeline advances and writes HI/LO in the same cycle.
- start while not in IDLE (or in DONE) is ignored; the operation in flight is unaffected.
- flush in any state: go to IDLE next edge, no done pulse, hi_o/lo_o unchanged. flush and start together in IDLE: start is ignored.

## Timing
- Reset (asynchronous): state IDLE, counter 0, stall_req 0 (unless start is high), done 0, hi_o 0, lo_o 0, hilo_bus 0.
- Reset mid-operation: aborts immediately; no done pulse follows.
- Latency, with start accepted at edge E0:
  - CALC occupies edges E1–E32; FIN follows E32; DONE follows E33.
  - Mul/div: done is high in the cycle after E33, i.e. 34 cycles after start is first presented.
  - Divide by zero: FIN follows E0, done is high after E1.
- Back-to-back: the earliest new start is accepted in the IDLE cycle after DONE.
- Outputs are registered and glitch-free. stall_req has a combinational term from start/flush in IDLE only.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF -> stall_req high for cycles 0–33, done in cycle 34, HI=0xFFFFFFFE, LO=0x00000001, hilo_bus[65:64]=11 only in that cycle.
- MULT 0xFFFFFFFD (-3) × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 -> done 2 cycles after start, HI=0x1234, LO=0xFFFFFFFF.
- Start MULTU 3×4, flush at cycle 10 -> no done, hi_o/lo_o keep the previous result. A new start in the next cycle completes normally with LO=12.
- Assert rst asynchronously mid-DIV -> all outputs 0 immediately, no done afterwards. A start held high during CALC is ignored and no extra operation runs.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Handshake and result bus between the EX stage and the multi-cycle mul/div unit.
// The master is the pipeline side and the slave is the unit.
interface mul_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_req;
  logic        done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [65:0] hilo_bus;

  modport master (
    output start, op, src_a, src_b, flush,
    input  stall_req, done, hi_o, lo_o, hilo_bus
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output stall_req, done, hi_o, lo_o, hilo_bus
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on unsigned magnitudes,
// with a sign fix-up before HI/LO are registered.
module mul_div_unit (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Datapath state. Only the control path above is reset.
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        div_q, div_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dbz_q, dbz_d;

  logic signed [31:0] src_a_s, src_b_s;
  logic               is_signed;
  logic [31:0]        mag_a, mag_b;
  logic [32:0]        mul_sum, div_shift, div_diff;
  logic [63:0]        mul_step, div_step, fin_res;
  logic               stall, done;

  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    logic [31:0] u;
    u = v;
    return u[31] ? (~u + 32'd1) : u;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  assign src_a_s   = bus.src_a;
  assign src_b_s   = bus.src_b;
  assign is_signed = ~bus.op[0];
  assign mag_a     = is_signed ? abs32(src_a_s) : bus.src_a;
  assign mag_b     = is_signed ? abs32(src_b_s) : bus.src_b;

  // One iteration of each algorithm. Multiply keeps {partial product, multiplier};
  // divide keeps {partial remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    mul_step  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_step  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0],  acc_q[30:0], 1'b1};
    if (dbz_q) begin
      fin_res = acc_q;
    end else if (div_q) begin
      fin_res = {(neg_rem_q ? neg32(acc_q[63:32]) : acc_q[63:32]),
                 (neg_q     ? neg32(acc_q[31:0])  : acc_q[31:0])};
    end else begin
      fin_res = neg_q ? neg64(acc_q) : acc_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    div_d     = div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    stall     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          stall     = 1'b1;
          cnt_d     = 5'd0;
          div_d     = bus.op[1];
          neg_d     = is_signed & (bus.src_a[31] ^ bus.src_b[31]);
          neg_rem_d = is_signed & bus.src_a[31];
          opnd_d    = bus.op[1] ? mag_b : mag_a;
          acc_d     = bus.op[1] ? {32'd0, mag_a} : {32'd0, mag_b};
          dbz_d     = 1'b0;
          state_d   = CALC;
          // Divide by zero bypasses the iterations with the final HI/LO preloaded.
          if (bus.op[1] && (bus.src_b == 32'd0)) begin
            dbz_d   = 1'b1;
            acc_d   = {bus.src_a, 32'hFFFF_FFFF};
            state_d = FIN;
          end
        end
      end
      CALC: begin
        stall = 1'b1;
        cnt_d = cnt_q + 5'd1;
        acc_d = div_q ? div_step : mul_step;
        if (cnt_q == 5'd31) state_d = FIN;
      end
      FIN: begin
        stall   = 1'b1;
        hi_d    = fin_res[63:32];
        lo_d    = fin_res[31:0];
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    opnd_q    <= opnd_d;
    div_q     <= div_d;
    neg_q     <= neg_d;
    neg_rem_q <= neg_rem_d;
    dbz_q     <= dbz_d;
  end

  assign done         = (state_q == DONE);
  assign bus.stall_req = stall;
  assign bus.done      = done;
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;
  assign bus.hilo_bus  = {done, done, hi_q, lo_q};

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases plus random operations checked against
// a plain-arithmetic HI/LO model.
module tb_mul_div_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mul_div_unit_if ifc ();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    h  = 32'd0;
    l  = 32'd0;
    case (o)
      2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'b01: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin uq = ua / ub; ur = ua % ub; h = ur[31:0]; l = uq[31:0]; end
      end
    endcase
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit hold);
    logic [31:0] eh, el;
    int          exp_cyc, cyc;
    bit          seen, stall_ok;
    model(o, a, b, eh, el);
    exp_cyc = (o[1] && b == 32'd0) ? 2 : 34;
    ifc.op    = o;
    ifc.src_a = a;
    ifc.src_b = b;
    ifc.start = 1'b1;
    #1 chk("stall_c0", 66'(ifc.stall_req), 66'd1);
    seen = 1'b0;
    stall_ok = 1'b1;
    cyc = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!hold) ifc.start = 1'b0;
      if (ifc.done) seen = 1'b1;
      else if (!ifc.stall_req) stall_ok = 1'b0;
    end
    ifc.start = 1'b0;
    chk("done_seen", 66'(seen), 66'd1);
    if (seen) begin
      chk("latency",    66'(cyc), 66'(exp_cyc));
      chk("stall_busy", 66'(stall_ok), 66'd1);
      chk("stall_done", 66'(ifc.stall_req), 66'd0);
      chk("hi",         66'(ifc.hi_o), 66'(eh));
      chk("lo",         66'(ifc.lo_o), 66'(el));
      chk("hilo_bus",   ifc.hilo_bus, {2'b11, eh, el});
    end
    @(negedge clk);
    chk("done_pulse", 66'(ifc.done), 66'd0);
    chk("bus_we",     66'(ifc.hilo_bus[65:64]), 66'd0);
    chk("hi_hold",    66'(ifc.hi_o), 66'(eh));
    chk("lo_hold",    66'(ifc.lo_o), 66'(el));
    chk("stall_idle", 66'(ifc.stall_req), 66'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] prev_h, prev_l;
    bit          saw_done;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.flush = 1'b0;
    ifc.op    = 2'b00;
    ifc.src_a = 32'd0;
    ifc.src_b = 32'd0;

    #12;
    chk("rst_stall", 66'(ifc.stall_req), 66'd0);
    chk("rst_done",  66'(ifc.done), 66'd0);
    chk("rst_hi",    66'(ifc.hi_o), 66'd0);
    chk("rst_lo",    66'(ifc.lo_o), 66'd0);
    chk("rst_bus",   ifc.hilo_bus, 66'd0);
    ifc.start = 1'b1;
    #1 chk("rst_stall_start", 66'(ifc.stall_req), 66'd1);
    ifc.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'h0000_1234, 32'd0, 1'b0);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);

    // Flush mid-multiply: no done, previous HI/LO kept, then an immediate restart.
    prev_h = ifc.hi_o;
    prev_l = ifc.lo_o;
    ifc.op = 2'b01; ifc.src_a = 32'd3; ifc.src_b = 32'd4; ifc.start = 1'b1;
    saw_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      if (ifc.done) saw_done = 1'b1;
    end
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    chk("flush_no_done", 66'(saw_done | ifc.done), 66'd0);
    chk("flush_idle",    66'(ifc.stall_req), 66'd0);
    chk("flush_hi",      66'(ifc.hi_o), 66'(prev_h));
    chk("flush_lo",      66'(ifc.lo_o), 66'(prev_l));
    run_op(2'b01, 32'd3, 32'd4, 1'b0);

    // Flush together with start in IDLE: start is dropped.
    ifc.op = 2'b11; ifc.src_a = 32'd9; ifc.src_b = 32'd0;
    ifc.start = 1'b1; ifc.flush = 1'b1;
    #1 chk("flush_start_stall", 66'(ifc.stall_req), 66'd0);
    @(negedge clk);
    ifc.start = 1'b0; ifc.flush = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ifc.done || ifc.stall_req) saw_done = 1'b1;
    end
    chk("flush_start_ignored", 66'(saw_done), 66'd0);
    chk("flush_start_lo", 66'(ifc.lo_o), 66'd12);

    // Start held through the whole operation launches nothing extra.
    run_op(2'b10, 32'd1000, 32'hFFFF_FFFD, 1'b1);

    // Asynchronous reset in the middle of a divide.
    ifc.op = 2'b10; ifc.src_a = 32'hFFFF_FFF9; ifc.src_b = 32'd2; ifc.start = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      ifc.start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_stall", 66'(ifc.stall_req), 66'd0);
    chk("arst_done",  66'(ifc.done), 66'd0);
    chk("arst_hi",    66'(ifc.hi_o), 66'd0);
    chk("arst_lo",    66'(ifc.lo_o), 66'd0);
    chk("arst_bus",   ifc.hilo_bus, 66'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ifc.done || ifc.stall_req) saw_done = 1'b1;
    end
    chk("arst_no_done", 66'(saw_done), 66'd0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
